// File: rtl/data_check_s_if.sv
// Receive-side bus of the test-pattern checker: byte stream in, lock/error status out.
// Capture outputs exist only when DATA_CHK_CAPTURE_EN is defined.
interface data_check_s_if #(
  parameter int CNT_W = 16
);
  logic [7:0]       data_in;
  logic             data_en;
  logic             err_clr;
  logic             locked;
  logic             err_flag;
  logic             lost_lock;
  logic [CNT_W-1:0] err_count;
  logic [CNT_W-1:0] frame_count;
`ifdef DATA_CHK_CAPTURE_EN
  logic             cap_valid;
  logic [7:0]       cap_exp;
  logic [7:0]       cap_got;
  logic [7:0]       cap_idx;
  logic [7:0]       cap_frame;

  modport master (
    output data_in, data_en, err_clr,
    input  locked, err_flag, lost_lock, err_count, frame_count,
    input  cap_valid, cap_exp, cap_got, cap_idx, cap_frame
  );
  modport slave (
    input  data_in, data_en, err_clr,
    output locked, err_flag, lost_lock, err_count, frame_count,
    output cap_valid, cap_exp, cap_got, cap_idx, cap_frame
  );
`else
  modport master (
    output data_in, data_en, err_clr,
    input  locked, err_flag, lost_lock, err_count, frame_count
  );
  modport slave (
    input  data_in, data_en, err_clr,
    output locked, err_flag, lost_lock, err_count, frame_count
  );
`endif
endinterface

// File: rtl/data_check_s.sv
// Test-pattern stream checker: hunts for the frame header, locks, counts errors and frames.
// Optional first-error capture registers are enabled with DATA_CHK_CAPTURE_EN.
module data_check_s #(
  parameter int LOCK_CNT = 8,
  parameter int LOSS_CNT = 4,
  parameter int CNT_W    = 16
) (
  input  logic         clk,
  input  logic         nRST,
  data_check_s_if.slave bus
);

  typedef enum logic [1:0] {HUNT, SYNC, LOCKED} state_t;

  localparam logic [7:0] LOCK_N = 8'(LOCK_CNT);
  localparam logic [7:0] LOSS_N = 8'(LOSS_CNT);

  state_t           state;
  logic             armed;
  logic [7:0]       exp_idx;
  logic [7:0]       exp_frame;
  logic [7:0]       run;
  logic [7:0]       miss;
  logic             locked;
  logic             err_flag;
  logic             lost_lock;
  logic [CNT_W-1:0] err_count;
  logic [CNT_W-1:0] frame_count;

  logic [7:0]       exp_byte;
  logic             match;
  logic [7:0]       run_inc;
  logic [7:0]       miss_inc;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  always_comb begin
    exp_byte = (exp_idx == 8'd0) ? exp_frame : exp_idx;
    match    = (bus.data_in == exp_byte);
    run_inc  = run + 8'd1;
    miss_inc = miss + 8'd1;
  end

`ifdef DATA_CHK_CAPTURE_EN
  logic       cap_valid;
  logic [7:0] cap_exp;
  logic [7:0] cap_got;
  logic [7:0] cap_idx;
  logic [7:0] cap_frame;

  // Holds the first locked mismatch until err_clr re-arms it.
  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      cap_valid <= 1'b0;
      cap_exp   <= 8'd0;
      cap_got   <= 8'd0;
      cap_idx   <= 8'd0;
      cap_frame <= 8'd0;
    end else if (bus.err_clr) begin
      cap_valid <= 1'b0;
      cap_exp   <= 8'd0;
      cap_got   <= 8'd0;
      cap_idx   <= 8'd0;
      cap_frame <= 8'd0;
    end else if (bus.data_en && state == LOCKED && !match && !cap_valid) begin
      cap_valid <= 1'b1;
      cap_exp   <= exp_byte;
      cap_got   <= bus.data_in;
      cap_idx   <= exp_idx;
      cap_frame <= exp_frame;
    end
  end

  assign bus.cap_valid = cap_valid;
  assign bus.cap_exp   = cap_exp;
  assign bus.cap_got   = cap_got;
  assign bus.cap_idx   = cap_idx;
  assign bus.cap_frame = cap_frame;
`endif

  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      state       <= HUNT;
      armed       <= 1'b0;
      exp_idx     <= 8'd0;
      exp_frame   <= 8'd0;
      run         <= 8'd0;
      miss        <= 8'd0;
      locked      <= 1'b0;
      err_flag    <= 1'b0;
      lost_lock   <= 1'b0;
      err_count   <= '0;
      frame_count <= '0;
    end else begin
      err_flag  <= 1'b0;
      lost_lock <= 1'b0;
      if (bus.data_en) begin
        case (state)
          HUNT: begin
            // The beat after a 255 is taken as the header, whatever its value.
            if (armed) begin
              exp_frame <= bus.data_in;
              exp_idx   <= 8'd1;
              run       <= 8'd0;
              armed     <= 1'b0;
              state     <= SYNC;
            end else if (bus.data_in == 8'hFF) begin
              armed <= 1'b1;
            end
          end
          SYNC: begin
            if (match) begin
              exp_idx <= exp_idx + 8'd1;
              if (exp_idx == 8'hFF) exp_frame <= exp_frame + 8'd1;
              run <= run_inc;
              if (run_inc == LOCK_N) begin
                state  <= LOCKED;
                locked <= 1'b1;
                miss   <= 8'd0;
              end
            end else begin
              state <= HUNT;
              armed <= 1'b0;
            end
          end
          LOCKED: begin
            // Position advances even on mismatch so isolated hits keep alignment.
            exp_idx <= exp_idx + 8'd1;
            if (exp_idx == 8'hFF) begin
              exp_frame   <= exp_frame + 8'd1;
              frame_count <= frame_count + 1'b1;
            end
            if (match) begin
              miss <= 8'd0;
            end else begin
              err_flag  <= 1'b1;
              err_count <= sat_inc(err_count);
              miss      <= miss_inc;
              if (miss_inc == LOSS_N) begin
                lost_lock <= 1'b1;
                locked    <= 1'b0;
                armed     <= 1'b0;
                state     <= HUNT;
              end
            end
          end
          default: begin
            state  <= HUNT;
            armed  <= 1'b0;
            locked <= 1'b0;
          end
        endcase
      end
      if (bus.err_clr) begin
        err_count   <= '0;
        frame_count <= '0;
      end
    end
  end

  assign bus.locked      = locked;
  assign bus.err_flag    = err_flag;
  assign bus.lost_lock   = lost_lock;
  assign bus.err_count   = err_count;
  assign bus.frame_count = frame_count;

endmodule

// File: tb/tb_data_check_s.sv
// Directed bench for data_check_s: a local pattern generator feeds the checker and
// hand-computed lock, error and frame expectations are compared after each step.
module tb_data_check_s;

  localparam int LOCK_CNT = 8;
  localparam int LOSS_CNT = 4;
  localparam int CNT_W    = 8;

  logic clk  = 1'b0;
  logic nRST = 1'b0;
  always #5 clk = ~clk;

  data_check_s_if #(.CNT_W(CNT_W)) bus ();

  data_check_s #(
    .LOCK_CNT(LOCK_CNT),
    .LOSS_CNT(LOSS_CNT),
    .CNT_W   (CNT_W)
  ) dut (
    .clk (clk),
    .nRST(nRST),
    .bus (bus)
  );

  int         checks = 0;
  int         errors = 0;
  logic [7:0] g_frame;
  logic [7:0] g_idx;
  logic       err_seen;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Drive one cycle, then sample the registered outputs just after the edge.
  task automatic cycle(input logic en, input logic [7:0] d, input logic clr);
    @(negedge clk);
    bus.data_en = en;
    bus.data_in = d;
    bus.err_clr = clr;
    @(posedge clk);
    #1;
    err_seen = err_seen | bus.err_flag;
  endtask

  function automatic logic [7:0] pat();
    return (g_idx == 8'd0) ? g_frame : g_idx;
  endfunction

  task automatic beat(input logic ovr, input logic [7:0] val, input logic clr);
    logic [7:0] d;
    d = ovr ? val : pat();
    cycle(1'b1, d, clr);
    if (g_idx == 8'hFF) g_frame = g_frame + 8'd1;
    g_idx = g_idx + 8'd1;
  endtask

  task automatic run_to(input logic [7:0] t);
    while (g_idx != t) beat(1'b0, 8'h00, 1'b0);
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_locked"},    32'(bus.locked),      0);
    chk({tag, "_err_flag"},  32'(bus.err_flag),    0);
    chk({tag, "_lost_lock"}, 32'(bus.lost_lock),   0);
    chk({tag, "_err_count"}, 32'(bus.err_count),   0);
    chk({tag, "_frame_cnt"}, 32'(bus.frame_count), 0);
`ifdef DATA_CHK_CAPTURE_EN
    chk({tag, "_cap_valid"}, 32'(bus.cap_valid),   0);
    chk({tag, "_cap_exp"},   32'(bus.cap_exp),     0);
`endif
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout checks=%0d", checks);
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    bus.data_en = 1'b0;
    bus.data_in = 8'h00;
    bus.err_clr = 1'b0;
    g_frame  = 8'd0;
    g_idx    = 8'd0;
    err_seen = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset");
    @(negedge clk);
    nRST = 1'b1;

    // Acquisition from reset: header at beat 257, lock on beat 265.
    repeat (264) beat(1'b0, 8'h00, 1'b0);
    chk("lock_beat264", 32'(bus.locked), 0);
    beat(1'b0, 8'h00, 1'b0);
    chk("lock_beat265", 32'(bus.locked), 1);
    run_to(8'hFF);
    beat(1'b0, 8'h00, 1'b0);
    chk("frame1_fc", 32'(bus.frame_count), 1);
    chk("frame1_ec", 32'(bus.err_count), 0);
    chk("frame1_flag_seen", 32'(err_seen), 0);

    // Single corruption at frame 3, idx 100.
    run_to(8'hFF);
    beat(1'b0, 8'h00, 1'b0);
    run_to(8'd100);
    beat(1'b1, 8'h00, 1'b0);
    chk("single_err_flag", 32'(bus.err_flag), 1);
    chk("single_err_count", 32'(bus.err_count), 1);
    chk("single_locked", 32'(bus.locked), 1);
`ifdef DATA_CHK_CAPTURE_EN
    chk("cap_valid", 32'(bus.cap_valid), 1);
    chk("cap_exp",   32'(bus.cap_exp),   100);
    chk("cap_got",   32'(bus.cap_got),   0);
    chk("cap_idx",   32'(bus.cap_idx),   100);
    chk("cap_frame", 32'(bus.cap_frame), 3);
`endif
    beat(1'b0, 8'h00, 1'b0);
    chk("idx101_flag", 32'(bus.err_flag), 0);
    chk("idx101_count", 32'(bus.err_count), 1);
    run_to(8'hFF);
    beat(1'b0, 8'h00, 1'b0);
    chk("frame3_fc", 32'(bus.frame_count), 3);

    // Idle-cycle clear, then four consecutive 0xAA bytes drop lock.
    run_to(8'd10);
    cycle(1'b0, 8'h00, 1'b1);
    chk("clr_ec", 32'(bus.err_count), 0);
    chk("clr_fc", 32'(bus.frame_count), 0);
    chk("clr_locked", 32'(bus.locked), 1);
`ifdef DATA_CHK_CAPTURE_EN
    chk("clr_cap_valid", 32'(bus.cap_valid), 0);
`endif
    repeat (3) beat(1'b1, 8'hAA, 1'b0);
    chk("burst3_locked", 32'(bus.locked), 1);
    chk("burst3_lost", 32'(bus.lost_lock), 0);
    chk("burst3_ec", 32'(bus.err_count), 3);
    beat(1'b1, 8'hAA, 1'b0);
    chk("burst4_ec", 32'(bus.err_count), 4);
    chk("burst4_lost", 32'(bus.lost_lock), 1);
    chk("burst4_locked", 32'(bus.locked), 0);
    beat(1'b0, 8'h00, 1'b0);
    chk("lost_pulse_end", 32'(bus.lost_lock), 0);
    n = 1;
    while (!bus.locked && n < 300) begin
      beat(1'b0, 8'h00, 1'b0);
      n++;
    end
    chk("relock", 32'(bus.locked), 1);
    chk("relock_within_bound", 32'(n <= 256 + LOCK_CNT), 1);

    // Gaps in data_en at idx 50 and idx 255.
    err_seen = 1'b0;
    run_to(8'd50);
    repeat (5) cycle(1'b0, 8'h00, 1'b0);
    run_to(8'hFF);
    repeat (5) cycle(1'b0, 8'h00, 1'b0);
    chk("gap_fc_before", 32'(bus.frame_count), 0);
    beat(1'b0, 8'h00, 1'b0);
    chk("gap_fc_after", 32'(bus.frame_count), 1);
    run_to(8'hFF);
    beat(1'b0, 8'h00, 1'b0);
    chk("gap_fc_next", 32'(bus.frame_count), 2);
    chk("gap_no_flag", 32'(err_seen), 0);
    chk("gap_ec", 32'(bus.err_count), 4);

    // Asynchronous reset while locked.
    run_to(8'd30);
    @(negedge clk);
    nRST = 1'b0;
    #2;
    check_all_zero("rst_locked");
    @(negedge clk);
    nRST = 1'b1;

    // Relock near frame 253 and run through the 255 -> 0 header wrap.
    g_frame  = 8'd253;
    g_idx    = 8'd200;
    err_seen = 1'b0;
    n = 0;
    while (!bus.locked && n < 300) begin
      beat(1'b0, 8'h00, 1'b0);
      n++;
    end
    chk("wrap_lock", 32'(bus.locked), 1);
    repeat (3) begin
      run_to(8'hFF);
      beat(1'b0, 8'h00, 1'b0);
    end
    chk("wrap_fc", 32'(bus.frame_count), 3);
    chk("wrap_ec", 32'(bus.err_count), 0);
    chk("wrap_no_flag", 32'(err_seen), 0);
    chk("wrap_locked", 32'(bus.locked), 1);

    // Saturate the error counter without losing lock.
    repeat (85) begin
      repeat (3) beat(1'b1, pat() ^ 8'h5A, 1'b0);
      beat(1'b0, 8'h00, 1'b0);
    end
    chk("sat_ec", 32'(bus.err_count), 255);
    chk("sat_locked", 32'(bus.locked), 1);
    beat(1'b1, pat() ^ 8'h5A, 1'b0);
    chk("sat_hold_ec", 32'(bus.err_count), 255);
    chk("sat_hold_flag", 32'(bus.err_flag), 1);
    beat(1'b0, 8'h00, 1'b0);

    // Clear coincident with an idx 255 beat wins over the increment.
    run_to(8'hFF);
    beat(1'b0, 8'h00, 1'b1);
    chk("clr255_fc", 32'(bus.frame_count), 0);
    chk("clr255_ec", 32'(bus.err_count), 0);
    chk("clr255_locked", 32'(bus.locked), 1);
    bus.err_clr = 1'b0;
    run_to(8'hFF);
    beat(1'b0, 8'h00, 1'b0);
    chk("post_clr_fc", 32'(bus.frame_count), 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/data_check_s.md
Name: data_check_s

Overview:
- Stream checker at the receiving end of the test-pattern byte stream produced by the data source in the SSD controller test path.
- Pattern is a 256-byte frame:
  - byte 0 = 8-bit frame number, incrementing each frame and wrapping 255→0.
  - bytes 1..255 = values 1..255.
- Block locks onto the pattern, checks every enabled byte, counts errors and completed frames, and detects loss of lock.

Parameters:
LOCK_CNT, 8, consecutive matching beats in SYNC required to declare lock (1..255)
LOSS_CNT, 4, consecutive mismatching beats in LOCKED that drop lock (1..255)
CNT_W, 16, width of err_count and frame_count

Ports:
clk  input  1  system clock, all logic on rising edge
nRST  input  1  asynchronous active-low reset
data_in  input  8  received byte
data_en  input  1  data_in valid this cycle (one beat)
err_clr  input  1  synchronous clear of err_count, frame_count (and capture regs)
locked  output  1  checker in LOCKED state
err_flag  output  1  one-cycle pulse: previous beat mismatched while LOCKED
lost_lock  output  1  one-cycle pulse on LOCKED→HUNT transition
err_count  output  CNT_W  saturating count of mismatched beats while LOCKED
frame_count  output  CNT_W  wrapping count of frames completed while LOCKED

Behaviour:
- Reset (nRST low, asynchronous): state=HUNT, all outputs 0, exp_idx=0, exp_frame=0, run counters 0.
- Beat definition: any cycle with data_en=1. Cycles with data_en=0 change nothing except the err_clr effect; pulses deassert.
- Expected value: exp_idx==0 → exp_frame; otherwise exp_idx. Every beat in SYNC/LOCKED advances exp_idx by 1, wrapping mod 256.
- Frame number update: on the idx 255 beat, exp_frame advances by 1, wrapping mod 256. exp_frame is never resynced from a received header while in SYNC or LOCKED.
- HUNT:
  - A beat with data_in==255 arms the header flag.
  - The next beat is taken as the header: exp_frame=data_in, exp_idx=1, run=0, state→SYNC.
  - A non-255 beat while armed is taken as the header anyway; a false alignment fails in SYNC.
- SYNC:
  - Match: run+1. When run reaches LOCK_CNT → LOCKED, locked=1 on the same edge.
  - Mismatch: → HUNT with header flag cleared. No err_count change.
- LOCKED:
  - Match: miss run cleared.
  - Mismatch: err_flag=1 for one cycle, err_count+1 (saturates at all-ones), miss run+1.
  - Miss run reaching LOSS_CNT: lost_lock=1 for one cycle, locked=0, state→HUNT. Position still advances on mismatch, so isolated corruption does not desynchronise.
  - Completed idx 255 beat (match or mismatch): frame_count+1, wrapping.
- Latency: all outputs registered and reflect beat N on the edge that samples beat N; visible the following cycle.
- err_clr=1: err_count and frame_count ← 0 on that edge. If err_clr and an increment coincide, the clear wins and the increment is lost. Lock state is unaffected.
- Header-255 alias: a 255 header followed by 1 is mistaken for an idx 255/header pair. The resulting SYNC mismatch returns to HUNT; this is required, not a bug.

Optional Feature:
- Macro: DATA_CHK_CAPTURE_EN.
- When defined, adds outputs:
  - cap_valid (1)
  - cap_exp (8)
  - cap_got (8)
  - cap_idx (8)
  - cap_frame (8)
- On the first LOCKED mismatch after reset or err_clr, capture expected byte, received byte, exp_idx and exp_frame, and set cap_valid. Later mismatches do not overwrite the capture. err_clr clears all capture registers; reset zeroes them.
- When undefined: ports absent, no capture logic.

Test Plan:
- Pattern source from reset, data_en=1 continuous, LOCK_CNT=8:
  - first 255 at beat 256; header (value 1) at beat 257.
  - locked=1 after beat 265 (data_in=8).
  - err_count=0 and frame_count=1 after next idx 255.
- Locked stream, frame 3, idx 100 forced to 0x00 → single err_flag pulse, err_count=1, locked stays 1, idx 101 value 101 matches.
- Locked stream, 4 consecutive bytes forced to 0xAA → err_count=4, lost_lock pulse on 4th, locked=0. Clean stream relocks within 256+LOCK_CNT beats.
- Locked stream with data_en low 5 cycles at idx 50 and at idx 255 → no err_flag, frame_count increments exactly once per frame.
- Frame 255→0 wrap (header 255 then header 0) while locked → no errors. err_count at 0xFFFF plus a mismatch stays at 0xFFFF.
- err_clr together with an idx 255 beat → frame_count=0. nRST pulse while locked → all outputs 0, state HUNT. With DATA_CHK_CAPTURE_EN: first corruption at frame 3, idx 100 → cap_exp=100, cap_got=0, cap_idx=100, cap_frame=3.
